// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: one-outstanding memory requester feeding a decode FIFO.
// Optional HALT-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module pipeline_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] IR_out,
    output logic [7:0]  PC_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

    state_t        state;
    logic [7:0]    fetch_pc;
    logic [7:0]    req_addr;
    logic          drop;

    logic [15:0]   q_ir [DEPTH];
    logic [7:0]    q_pc [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          grant;
    logic          push;
    logic          pop;
    logic          is_halt;

    // A redirect suppresses the request so no grant can race the flush.
    assign mem_req  = (state == ISSUE) && (count < CW'(DEPTH)) && !redirect;
    assign mem_addr = fetch_pc;
    assign grant    = mem_req && mem_gnt;

    assign ir_valid = (count != '0);
    assign IR_out   = ir_valid ? q_ir[rd_ptr] : 16'h0000;
    assign PC_out   = ir_valid ? q_pc[rd_ptr] : 8'h00;

    assign push = (state == WAIT) && mem_rvalid && !drop && !redirect;
    assign pop  = ir_valid && ir_ready && !redirect;

`ifdef FETCH_HALT_DETECT_EN
    assign is_halt = (mem_rdata[15:13] == 3'b111);
    assign halted  = (state == HALT);
`else
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ISSUE;
                    if (redirect) fetch_pc <= redirect_pc;
                end
                ISSUE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (grant) begin
                        req_addr <= fetch_pc;
                        fetch_pc <= fetch_pc + 8'd1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (mem_rvalid) begin
                            drop  <= 1'b0;
                            state <= ISSUE;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (mem_rvalid) begin
                        drop  <= 1'b0;
                        state <= (!drop && is_halt) ? HALT : ISSUE;
                    end
                end
                HALT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        state    <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_ir[i] <= 16'h0000;
                q_pc[i] <= 8'h00;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_ir[wr_ptr] <= mem_rdata;
                q_pc[wr_ptr] <= req_addr;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: directed vectors, corner sequences and a
// randomized run against a stream-level reference model.
module tb_pipeline_fetch_unit;

    localparam int DEPTH = 4;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] IR_out;
    logic [7:0]  PC_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;

    pipeline_fetch_unit #(.RESET_PC(8'h00), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .IR_out(IR_out), .PC_out(PC_out), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem_img [256];
    int          lat;
    bit          spur_en;
    int          checks;
    int          errors;

    // memory responder: one response per grant after lat cycles
    logic        r_g;
    logic [7:0]  r_ga;
    logic [7:0]  r_pa;
    int          r_dly;
    bit          r_pend;

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        r_pend     = 1'b0;
        r_dly      = 0;
        r_pa       = 8'h00;
        forever begin
            @(negedge clk);
            r_g  = mem_req && mem_gnt;
            r_ga = mem_addr;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
            if (r_g) begin
                r_pend = 1'b1;
                r_pa   = r_ga;
                r_dly  = lat - 1;
            end
            if (r_pend) begin
                if (r_dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_img[r_pa];
                    r_pend     = 1'b0;
                end else begin
                    r_dly--;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 16'hE000 | 16'($urandom_range(0, 255));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // values sampled at the falling edge before each rising edge
    logic        s_valid, s_fire, s_gnt, s_req, s_halted;
    logic [7:0]  s_pc, s_addr;
    logic [15:0] s_ir;

    // reference model: decode must see the address stream in program order
    bit          m_idle, m_out, m_drop, m_halt;
    int          m_q;
    logic [7:0]  m_pc, m_req;

    task automatic model();
        logic exp_req;
        if (!rst_n) begin
            m_idle = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_halt = 1'b0;
            m_q = 0; m_pc = 8'h00; m_req = 8'h00;
            return;
        end
        exp_req = !m_idle && !m_out && !m_halt && (m_q < DEPTH);
        if (!redirect) chk("mem_req", s_req, exp_req);
        chk("ir_valid", s_valid, m_q != 0);
        chk("halted", s_halted, m_halt);
        if (s_valid) chk("ir_data", s_ir, mem_img[s_pc]);
        if (redirect) begin
            if (m_out && mem_rvalid) begin
                m_out = 1'b0; m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
            m_q = 0; m_halt = 1'b0;
            m_pc = redirect_pc; m_req = redirect_pc;
        end else begin
            if (mem_rvalid && m_out) begin
                if (!m_drop) begin
                    m_q++;
                    if (HALT_EN && mem_rdata[15:13] == 3'b111) m_halt = 1'b1;
                end
                m_out = 1'b0; m_drop = 1'b0;
            end
            if (s_fire) begin
                chk("pop_pc", s_pc, m_pc);
                m_pc = m_pc + 8'd1;
                m_q--;
            end
            if (s_gnt) begin
                chk("req_addr", s_addr, m_req);
                m_req = m_req + 8'd1;
                m_out = 1'b1;
            end
        end
        m_idle = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        s_valid  = ir_valid;
        s_fire   = ir_valid && ir_ready;
        s_pc     = PC_out;
        s_ir     = IR_out;
        s_gnt    = mem_req && mem_gnt;
        s_addr   = mem_addr;
        s_req    = mem_req;
        s_halted = halted;
        model();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] pops [$];

    task automatic collect(input int n, input int budget);
        pops.delete();
        for (int i = 0; i < budget && pops.size() < n; i++) begin
            step();
            if (s_fire) pops.push_back({s_ir, s_pc});
        end
        chk("pop_count", pops.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; mem_gnt = 1'b0; ir_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic redir(input logic [7:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    typedef struct {
        logic [7:0] tgt;
        int         lat;
        int         n;
        logic [7:0] last;
    } vec_t;

    vec_t        tbl [5];
    int          ngnt;
    bit          found;
    bit          g04;
    logic [7:0]  e;

    initial begin
        tbl[0] = '{8'h10, 1, 3, 8'h12};
        tbl[1] = '{8'hFE, 1, 4, 8'h01};
        tbl[2] = '{8'h80, 2, 5, 8'h84};
        tbl[3] = '{8'hF0, 3, 2, 8'hF1};
        tbl[4] = '{8'h20, 1, 6, 8'h25};

        checks = 0; errors = 0;
        for (int i = 0; i < 256; i++)
            mem_img[i] = {3'($urandom_range(0, 6)), 13'($urandom)};
        mem_img[3] = 16'hE000;

        rst_n = 1'b0; mem_gnt = 1'b0; ir_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 8'h00; lat = 1; spur_en = 1'b0;

        step();
        step();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_ir_out", IR_out, 16'h0000);
        chk("rst_pc_out", PC_out, 8'h00);
        chk("rst_halted", halted, 1'b0);

        // in-order fetch from reset
        rst_n = 1'b1; mem_gnt = 1'b1; ir_ready = 1'b1; lat = 1;
        collect(3, 40);
        for (int j = 0; j < pops.size(); j++)
            chk("order_pc", pops[j][7:0], j);

        // decode stall fills the queue
        do_reset();
        ir_ready = 1'b0; mem_gnt = 1'b1; lat = 1; ngnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (s_gnt) ngnt++;
        end
        chk("stall_grants", ngnt, DEPTH);
        chk("stall_req", s_req, 1'b0);
        chk("stall_valid", s_valid, 1'b1);
        chk("stall_pc", s_pc, 8'h00);

        // redirect while the request for 05 is outstanding
        do_reset();
        ir_ready = 1'b1; mem_gnt = 1'b1; lat = 3; found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (s_gnt && s_addr == 8'h05) found = 1'b1;
        end
        chk("wait05_seen", found, 1'b1);
        ir_ready = 1'b0;
        redir(8'h40);
        step();
        chk("flush_valid", s_valid, 1'b0);
        ir_ready = 1'b1;
        collect(1, 40);
        if (pops.size() > 0) chk("redir_pc", pops[0][7:0], 8'h40);

        // vector table: redirect target, latency, pops, expected last PC
        for (int k = 0; k < 5; k++) begin
            lat = tbl[k].lat; ir_ready = 1'b1; mem_gnt = 1'b1;
            redir(tbl[k].tgt);
            collect(tbl[k].n, 60);
            for (int j = 0; j < pops.size(); j++) begin
                e = tbl[k].tgt + 8'(j);
                chk("vec_pc", pops[j][7:0], e);
            end
            if (pops.size() > 0)
                chk("vec_last", pops[pops.size()-1][7:0], tbl[k].last);
        end

        // HALT opcode at address 03
        ir_ready = 1'b1; mem_gnt = 1'b1; lat = 1;
`ifdef FETCH_HALT_DETECT_EN
        redir(8'h01);
        pops.delete(); g04 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_fire) pops.push_back({s_ir, s_pc});
            if (s_gnt && s_addr == 8'h04) g04 = 1'b1;
        end
        chk("halt_set", s_halted, 1'b1);
        chk("halt_no04", g04, 1'b0);
        chk("halt_drain", pops.size(), 3);
        if (pops.size() == 3) chk("halt_word", pops[2][23:8], 16'hE000);
        redir(8'h10);
        step();
        chk("halt_clear", s_halted, 1'b0);
        collect(1, 30);
        if (pops.size() > 0) chk("halt_resume", pops[0][7:0], 8'h10);
`else
        redir(8'h02);
        collect(3, 40);
        if (pops.size() == 3) begin
            chk("e000_pc", pops[1][7:0], 8'h03);
            chk("e000_word", pops[1][23:8], 16'hE000);
            chk("e000_next", pops[2][7:0], 8'h04);
        end
        chk("no_halt", s_halted, 1'b0);
`endif

        // reset while a request is outstanding
        do_reset();
        ir_ready = 1'b0; mem_gnt = 1'b1; lat = 3; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (s_gnt && s_addr == 8'h02) found = 1'b1;
        end
        chk("rwait_seen", found, 1'b1);
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_valid", ir_valid, 1'b0);
        chk("async_req", mem_req, 1'b0);
        chk("async_addr", mem_addr, 8'h00);
        chk("async_pc", PC_out, 8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stale_valid", s_valid, 1'b0);
        end
        mem_gnt = 1'b1; lat = 1; ir_ready = 1'b1;
        collect(1, 30);
        if (pops.size() > 0) chk("rwait_pc", pops[0][7:0], 8'h00);

        // randomized traffic
        do_reset();
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            mem_gnt     = ($urandom_range(0, 3) != 0);
            ir_ready    = ($urandom_range(0, 2) != 0);
            lat         = $urandom_range(1, 3);
            redirect    = ($urandom_range(0, 31) == 0);
            redirect_pc = 8'($urandom);
            step();
        end
        redirect = 1'b0;
        spur_en  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
